router_sync_ctrl: RTL and testbench

Steering and supervision controller between the router input FSM and the three output FIFOs of the 1x3 router.
- Latches the destination address from the packet header.
- Decodes per-FIFO write enables and returns the selected FIFO's full status to the FSM.
- Drives per-port valid-out from FIFO empty flags.
- Runs a per-port read-timeout counter that pulses a one-cycle soft reset to flush a FIFO whose destination stops reading.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_timeout_ctr.sv | 81 ++++++++
 rtl/router_sync_ctrl.sv | 113 +++++++++++
 tb/tb_router_sync_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants and types for the 1x3 router sync
//                controller (port count, invalid address code, timeout
//                length and the destination address type).
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int NUM_PORTS      = 3;
    localparam int TIMEOUT_CYCLES = 30;
    localparam int CNT_W          = 5;

    // Destination address carried in header byte [1:0]
    typedef logic [1:0] router_addr_t;

    // Code 3 has no FIFO behind it; packets addressed there are dropped
    localparam router_addr_t ADDR_INVALID = 2'b11;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : router_timeout_ctr
//  Description : Per-port read-timeout supervisor. Counts consecutive cycles
//                in which the port holds valid data that the destination does
//                not read; after TIMEOUT_CYCLES such cycles it emits a
//                one-cycle soft reset that flushes the port's FIFO.
//  Ports       : clk        - system clock (rising edge)
//                reset      - synchronous active-high reset
//                vld        - port has data (FIFO not empty)
//                rd         - destination read strobe
//                soft_reset - one-cycle FIFO flush pulse
//                sticky     - latched "a flush happened" flag, cleared only
//                             by reset (ROUTER_TIMEOUT_STATUS_EN only)
//  Config      : ROUTER_TIMEOUT_STATUS_EN adds the sticky status output.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int CNT_W          = 5    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
`ifdef ROUTER_TIMEOUT_STATUS_EN
    ,
    output logic sticky
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_reset;
    logic             w_expire;

    // Counter reached the final idle cycle and nothing higher-priority
    // (pulse in progress, not valid, read) intervenes this edge.
    assign w_expire = !r_soft_reset && vld && !rd && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (r_soft_reset) begin
            // Pulse is always exactly one cycle; the count restarts after it
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (w_expire) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_soft_reset <= 1'b0;
        end
    end

    assign soft_reset = r_soft_reset;

`ifdef ROUTER_TIMEOUT_STATUS_EN
    logic r_sticky;

    // Sets on the same edge the flush pulse is raised
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (w_expire) begin
            r_sticky <= 1'b1;
        end
    end

    assign sticky = r_sticky;
`endif

endmodule : router_timeout_ctr
`default_nettype wire

// File: rtl/router_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_sync_ctrl
//  Description : Steering and supervision controller between the router
//                input FSM and the three output FIFOs. Latches the header
//                destination address, decodes one-hot FIFO write enables,
//                returns the addressed FIFO's full flag, drives per-port
//                valid-out and supervises each port with a read timeout.
//  Ports       : clk            - system clock (rising edge)
//                reset          - synchronous active-high reset
//                detect_add     - header strobe, latch data_in this cycle
//                data_in[1:0]   - destination address from header byte
//                write_enb_reg  - FSM request to write the current byte
//                read_enb[2:0]  - per-port read strobes
//                empty[2:0]     - per-FIFO empty flags
//                full[2:0]      - per-FIFO full flags
//                write_enb[2:0] - one-hot FIFO write enables
//                fifo_full      - full flag of the addressed FIFO
//                vld_out[2:0]   - per-port data valid
//                soft_reset[2:0]- per-FIFO one-cycle flush pulse
//                timeout_sticky[2:0] - per-port latched flush flag
//                                 (ROUTER_TIMEOUT_STATUS_EN only)
//  Config      : ROUTER_TIMEOUT_STATUS_EN adds timeout_sticky.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_sync_ctrl #(
    parameter int NUM_PORTS      = router_pkg::NUM_PORTS,
    parameter int TIMEOUT_CYCLES = router_pkg::TIMEOUT_CYCLES,
    parameter int CNT_W          = router_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 detect_add,
    input  logic [1:0]           data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] full,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset
`ifdef ROUTER_TIMEOUT_STATUS_EN
    ,
    output logic [NUM_PORTS-1:0] timeout_sticky
`endif
);

    import router_pkg::*;

    router_addr_t         r_addr;
    logic [NUM_PORTS-1:0] w_vld;

    // ------------------------------------------------------------------
    // Destination address latch. A write in the same cycle as detect_add
    // still steers by the previous address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= ADDR_INVALID;
        end else if (detect_add) begin
            r_addr <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Write decode. Not gated by full: the FIFO blocks its own writes.
    // Address 3 matches no port, so nothing is written.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wr_dec
            assign write_enb[g] = write_enb_reg && (r_addr == router_addr_t'(g));
        end
    endgenerate

    // Full select; invalid address reports not-full so the FSM can
    // drain and drop the packet.
    always_comb begin
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_addr == router_addr_t'(i)) begin
                fifo_full = full[i];
            end
        end
    end

    assign w_vld   = ~empty;
    assign vld_out = w_vld;

    // ------------------------------------------------------------------
    // Independent per-port read-timeout supervisors
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timeout
            router_timeout_ctr #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .CNT_W          (CNT_W)
            ) u_timeout_ctr (
                .clk        (clk),
                .reset      (reset),
                .vld        (w_vld[g]),
                .rd         (read_enb[g]),
                .soft_reset (soft_reset[g])
`ifdef ROUTER_TIMEOUT_STATUS_EN
                ,
                .sticky     (timeout_sticky[g])
`endif
            );
        end
    endgenerate

endmodule : router_sync_ctrl
`default_nettype wire

// File: tb/tb_router_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_sync_ctrl
//  Description : Directed self-checking bench for router_sync_ctrl. Inputs
//                change 1 ns after a rising edge; outputs are checked there.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_sync_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] read_enb;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
`ifdef ROUTER_TIMEOUT_STATUS_EN
    logic [2:0] timeout_sticky;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    router_sync_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out       (vld_out),
        .soft_reset    (soft_reset)
`ifdef ROUTER_TIMEOUT_STATUS_EN
        ,
        .timeout_sticky(timeout_sticky)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b1;
        read_enb      = 3'b000;
        empty         = 3'b111;
        full          = 3'b111;
        tick();
        tick();

        // Reset state: address invalid, nothing enabled
        check("rst_write_enb", 32'(write_enb), 32'h0);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_soft_reset", 32'(soft_reset), 32'h0);
        check("rst_vld_out", 32'(vld_out), 32'h0);
`ifdef ROUTER_TIMEOUT_STATUS_EN
        check("rst_sticky", 32'(timeout_sticky), 32'h0);
`endif

        // Address 01: same-cycle write uses old (invalid) address
        reset      = 1'b0;
        full       = 3'b000;
        detect_add = 1'b1;
        data_in    = 2'b01;
        #1;
        check("same_cycle_old_addr", 32'(write_enb), 32'h0);
        tick();
        detect_add = 1'b0;
        data_in    = 2'b00;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("addr1_write_enb", 32'(write_enb), 32'h2);
            tick();
        end
        full = 3'b010;
        #1;
        check("addr1_full_set", 32'(fifo_full), 32'h1);
        full = 3'b101;
        #1;
        check("addr1_full_clr", 32'(fifo_full), 32'h0);
        write_enb_reg = 1'b0;
        #1;
        check("addr1_no_req", 32'(write_enb), 32'h0);

        // Address 10
        detect_add = 1'b1;
        data_in    = 2'b10;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b100;
        #1;
        check("addr2_write_enb", 32'(write_enb), 32'h4);
        check("addr2_full", 32'(fifo_full), 32'h1);

        // Address 00
        detect_add = 1'b1;
        data_in    = 2'b00;
        tick();
        detect_add = 1'b0;
        full       = 3'b001;
        #1;
        check("addr0_write_enb", 32'(write_enb), 32'h1);
        check("addr0_full", 32'(fifo_full), 32'h1);

        // Invalid address 11
        detect_add = 1'b1;
        data_in    = 2'b11;
        tick();
        detect_add = 1'b0;
        full       = 3'b111;
        #1;
        check("addr3_write_enb", 32'(write_enb), 32'h0);
        check("addr3_full", 32'(fifo_full), 32'h0);
        write_enb_reg = 1'b0;

        // Valid-out is the inverse of empty (no edge taken here)
        empty = 3'b010;
        #1;
        check("vld_out_101", 32'(vld_out), 32'h5);
        empty = 3'b111;
        #1;

        // Port 2 timeout: pulse after the 30th idle edge, one cycle long
        empty = 3'b011;
        for (int i = 1; i <= 29; i++) begin
            tick();
            check("p2_pre_timeout", 32'(soft_reset), 32'h0);
        end
        tick();
        check("p2_timeout_pulse", 32'(soft_reset), 32'h4);
`ifdef ROUTER_TIMEOUT_STATUS_EN
        check("p2_sticky", 32'(timeout_sticky), 32'h4);
`endif
        tick();
        check("p2_pulse_one_cycle", 32'(soft_reset), 32'h0);
        empty = 3'b111;
        tick();

        // Read on edge 30 cancels the flush
        empty = 3'b011;
        for (int i = 1; i <= 29; i++) tick();
        read_enb = 3'b100;
        tick();
        read_enb = 3'b000;
        check("p2_read_edge30_cancel", 32'(soft_reset), 32'h0);
        tick();
        check("p2_after_cancel", 32'(soft_reset), 32'h0);
        empty = 3'b111;
        tick();

        // Read on edge 29 restarts the count; 30 further idle edges flush
        empty = 3'b011;
        for (int i = 1; i <= 28; i++) tick();
        read_enb = 3'b100;
        tick();
        read_enb = 3'b000;
        for (int i = 1; i <= 29; i++) begin
            tick();
            check("p2_restart_pre", 32'(soft_reset), 32'h0);
        end
        tick();
        check("p2_restart_pulse", 32'(soft_reset), 32'h4);
        empty = 3'b111;
        tick();
        check("p2_restart_end", 32'(soft_reset), 32'h0);

        // Ports 0 and 1 simultaneous timeout
        empty = 3'b100;
        for (int i = 1; i <= 29; i++) tick();
        check("p01_pre_timeout", 32'(soft_reset), 32'h0);
        tick();
        check("p01_timeout_pulse", 32'(soft_reset), 32'h3);
`ifdef ROUTER_TIMEOUT_STATUS_EN
        check("p01_sticky", 32'(timeout_sticky), 32'h7);
`endif
        empty = 3'b111;
        tick();
        check("p01_pulse_end", 32'(soft_reset), 32'h0);

        // Reset at cycle 15 of a timeout run
        detect_add = 1'b1;
        data_in    = 2'b01;
        tick();
        detect_add = 1'b0;
        empty      = 3'b011;
        for (int i = 1; i <= 15; i++) tick();
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        #1;
        check("midrst_addr_invalid", 32'(write_enb), 32'h0);
        check("midrst_fifo_full", 32'(fifo_full), 32'h0);
`ifdef ROUTER_TIMEOUT_STATUS_EN
        check("midrst_sticky_clr", 32'(timeout_sticky), 32'h0);
`endif
        write_enb_reg = 1'b0;
        for (int i = 1; i <= 29; i++) begin
            tick();
            check("midrst_no_pulse", 32'(soft_reset), 32'h0);
        end
        tick();
        check("midrst_full_run_pulse", 32'(soft_reset), 32'h4);
        empty = 3'b111;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_router_sync_ctrl
`default_nettype wire
